// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared types and constants for the instruction-fetch stage
package fetcher_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] data_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Default cache geometry; the top-level parameter may override it.
  localparam int ICACHE_LINES_DEFAULT = 64;
  localparam int ICACHE_IDX_W_DEFAULT = $clog2(ICACHE_LINES_DEFAULT);
  typedef logic [ICACHE_IDX_W_DEFAULT-1:0]      icache_idx_t;
  typedef logic [31-ICACHE_IDX_W_DEFAULT-2:0]   icache_tag_t;

  // IDLE: looking up / issuing from pc; MEM_WAIT: request outstanding at the controller.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } fetch_state_e;

  // Sequential fetch advances one word; wraps modulo 2^32.
  function automatic addr_t next_pc(addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped one-word-per-line instruction cache
module fetcher_icache #(
  parameter int LINES = 64,
  parameter int IDX   = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_rd_word,
  output logic        o_hit,
  output logic [31:0] o_rd_data,
  input  logic        i_wr_en,
  input  logic [29:0] i_wr_word,
  input  logic [31:0] i_wr_data
);

  localparam int TAG_W = 30 - IDX;

  logic [31:0]      r_data  [LINES];
  logic [TAG_W-1:0] r_tag   [LINES];
  logic [LINES-1:0] r_valid;

  logic [IDX-1:0]   w_rd_idx;
  logic [IDX-1:0]   w_wr_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [TAG_W-1:0] w_wr_tag;

  // Word address splits into index (low bits) and tag (remaining high bits).
  assign w_rd_idx  = i_rd_word[IDX-1:0];
  assign w_rd_tag  = i_rd_word[29:IDX];
  assign w_wr_idx  = i_wr_word[IDX-1:0];
  assign w_wr_tag  = i_wr_word[29:IDX];

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_data = r_data[w_rd_idx];

  // Valid bits are the only cache state that needs reset; cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Data and tag arrays are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[w_wr_idx] <= i_wr_data;
      r_tag[w_wr_idx]  <= w_wr_tag;
    end
  end

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction-fetch stage; ICACHE_EN selects the cached build
module fetcher
  import fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rdy,
  input  logic        i_full_from_rob,
  input  logic        i_full_from_rs,
  input  logic        i_full_from_lsb,
  input  logic        i_commit_jump_flag_from_rob,
  input  logic [31:0] i_target_pc_from_rob,
  output logic        o_ena_to_mc,
  output logic [31:0] o_addr_to_mc,
  input  logic        i_ok_flag_from_mc,
  input  logic [31:0] i_inst_from_mc,
  output logic        o_ok_flag_to_dsp,
  output logic [31:0] o_inst_to_dsp,
  output logic [31:0] o_pc_to_dsp
);

  // Cache geometry guard: index extraction assumes a power-of-two line count.
  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two and at least 2");
  end

  fetch_state_e r_state;
  addr_t        r_pc;
  logic         r_ena;
  addr_t        r_addr;
  logic         r_ok;
  inst_t        r_inst;
  addr_t        r_pc_dsp;

  logic         w_stall;

  assign w_stall          = i_full_from_rob | i_full_from_rs | i_full_from_lsb;

  assign o_ena_to_mc      = r_ena;
  assign o_addr_to_mc     = r_addr;
  assign o_ok_flag_to_dsp = r_ok;
  assign o_inst_to_dsp    = r_inst;
  assign o_pc_to_dsp      = r_pc_dsp;

`ifdef ICACHE_EN
  logic  w_hit;
  inst_t w_line;
  logic  w_fill;

  // A response landing with a redirect is still written: its data matches r_addr.
  assign w_fill = i_rdy && (r_state == ST_MEM_WAIT) && i_ok_flag_from_mc;

  fetcher_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .i_rd_word (r_pc[31:2]),
    .o_hit     (w_hit),
    .o_rd_data (w_line),
    .i_wr_en   (w_fill),
    .i_wr_word (r_addr[31:2]),
    .i_wr_data (i_inst_from_mc)
  );
`endif

  // Fetch FSM: redirect beats memory fill beats issue; rdy low freezes all state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ena    <= FALSE;
      r_addr   <= '0;
      r_ok     <= FALSE;
      r_inst   <= '0;
      r_pc_dsp <= '0;
    end else if (i_rdy) begin
      r_ok <= FALSE;
      if (i_commit_jump_flag_from_rob) begin
        r_pc <= i_target_pc_from_rob;
        if (r_state == ST_MEM_WAIT) begin
          r_ena   <= FALSE;
          r_state <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
`ifdef ICACHE_EN
            if (!w_hit) begin
              r_ena   <= TRUE;
              r_addr  <= r_pc;
              r_state <= ST_MEM_WAIT;
            end else if (!w_stall) begin
              r_inst   <= w_line;
              r_pc_dsp <= r_pc;
              r_ok     <= TRUE;
              r_pc     <= next_pc(r_pc);
            end
`else
            if (!w_stall) begin
              r_ena   <= TRUE;
              r_addr  <= r_pc;
              r_state <= ST_MEM_WAIT;
            end
`endif
          end
          ST_MEM_WAIT: begin
            if (i_ok_flag_from_mc) begin
              r_ena   <= FALSE;
              r_state <= ST_IDLE;
`ifndef ICACHE_EN
              r_inst   <= i_inst_from_mc;
              r_pc_dsp <= r_pc;
              r_ok     <= TRUE;
              r_pc     <= next_pc(r_pc);
`endif
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
